// File: rtl/scr1_tb_ahb_resp_ctrl.sv
// AHB-Lite slave response controller for the SCR1 testbench memory: per-channel
// wait-state / error-response generation, data-phase strobe and statistics.

module scr1_tb_ahb_resp_ctrl_ch #(
  parameter int          WS_W = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_cfg_mode,
  input  logic [WS_W-1:0] i_cfg_ws,
  input  logic [31:0]     i_cfg_err_addr,
  input  logic [31:0]     i_cfg_err_mask,
  input  logic [1:0]      i_htrans,
  input  logic [31:0]     i_haddr,
  output logic            o_hready,
  output logic            o_hresp,
  output logic            o_dphase_vld,
  output logic [31:0]     o_dphase_addr,
  output logic [31:0]     o_stat_xfer_cnt,
  output logic [15:0]     o_stat_err_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t          r_state;
  logic [WS_W-1:0] r_cnt;
  logic            r_err_pend;
  logic [15:0]     r_lfsr;
  logic [31:0]     r_addr;
  logic            r_hready;
  logic            r_hresp;
  logic            r_dvld;
  logic [31:0]     r_xfer;
  logic [15:0]     r_errc;

  state_t          w_state_n;
  logic [WS_W-1:0] w_cnt_n;
  logic            w_errp_n;
  logic            w_acc;
  logic            w_fb;
  logic [WS_W-1:0] w_rnd;
  logic [WS_W-1:0] w_ws;
  logic            w_errp_ld;
  logic            w_hready_n;
  logic            w_hresp_n;
  logic            w_dvld_n;
  logic            w_unused;

  // IDLE and BUSY look the same to a slave; only htrans[1] matters.
  assign w_unused = i_htrans[0];

  always_comb begin
    w_acc     = r_hready & i_htrans[1];
    w_fb      = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    w_rnd     = r_lfsr[WS_W-1:0];
    w_errp_ld = (i_cfg_mode == 2'b11) &&
                (((i_haddr ^ i_cfg_err_addr) & i_cfg_err_mask) == 32'd0);
    case (i_cfg_mode)
      2'b00:   w_ws = '0;
      2'b01:   w_ws = i_cfg_ws;
      default: w_ws = (w_rnd < i_cfg_ws) ? w_rnd : i_cfg_ws;
    endcase

    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_errp_n  = r_err_pend;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (w_acc) begin
          w_state_n = ST_DATA;
          w_cnt_n   = w_ws;
          w_errp_n  = w_errp_ld;
        end else begin
          w_state_n = ST_IDLE;
          w_errp_n  = 1'b0;
        end
      end
      ST_DATA: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - WS_W'(1);
        end else if (w_acc) begin
          w_cnt_n  = w_ws;
          w_errp_n = w_errp_ld;
        end else begin
          w_state_n = ST_IDLE;
          w_errp_n  = 1'b0;
        end
      end
      ST_ERR1: w_state_n = ST_ERR2;
      default: w_state_n = ST_IDLE;
    endcase

    // An errored transfer leaves DATA the moment its wait count would expire,
    // so the first error cycle lands exactly where OKAY completion would have.
    if (w_state_n == ST_DATA && w_cnt_n == '0 && w_errp_n) begin
      w_state_n = ST_ERR1;
      w_errp_n  = 1'b0;
    end

    w_hready_n = (w_state_n != ST_ERR1) && !(w_state_n == ST_DATA && w_cnt_n != '0);
    w_hresp_n  = (w_state_n == ST_ERR1) || (w_state_n == ST_ERR2);
    w_dvld_n   = (w_state_n == ST_DATA) && (w_cnt_n == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
      r_lfsr     <= SEED;
      r_addr     <= '0;
      r_hready   <= 1'b1;
      r_hresp    <= 1'b0;
      r_dvld     <= 1'b0;
      r_xfer     <= '0;
      r_errc     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_err_pend <= w_errp_n;
      r_hready   <= w_hready_n;
      r_hresp    <= w_hresp_n;
      r_dvld     <= w_dvld_n;
      if (w_acc) begin
        r_addr <= i_haddr;
        r_lfsr <= {w_fb, r_lfsr[15:1]};
      end
      if (r_dvld)
        r_xfer <= r_xfer + 32'd1;
      if (r_state == ST_ERR2 && r_errc != 16'hFFFF)
        r_errc <= r_errc + 16'd1;
    end
  end

  assign o_hready        = r_hready;
  assign o_hresp         = r_hresp;
  assign o_dphase_vld    = r_dvld;
  assign o_dphase_addr   = r_addr;
  assign o_stat_xfer_cnt = r_xfer;
  assign o_stat_err_cnt  = r_errc;

endmodule

module scr1_tb_ahb_resp_ctrl #(
  parameter int          NCH       = 2,
  parameter int          WS_W      = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NCH-1:0][1:0]       i_cfg_mode,
  input  logic [NCH-1:0][WS_W-1:0]  i_cfg_ws,
  input  logic [NCH-1:0][31:0]      i_cfg_err_addr,
  input  logic [NCH-1:0][31:0]      i_cfg_err_mask,
  input  logic [NCH-1:0][1:0]       i_htrans,
  input  logic [NCH-1:0][31:0]      i_haddr,
  output logic [NCH-1:0]            o_hready,
  output logic [NCH-1:0]            o_hresp,
  output logic [NCH-1:0]            o_dphase_vld,
  output logic [NCH-1:0][31:0]      o_dphase_addr,
  output logic [NCH-1:0][31:0]      o_stat_xfer_cnt,
  output logic [NCH-1:0][15:0]      o_stat_err_cnt
);

  // Each channel gets a distinct seed so random wait patterns decorrelate.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [15:0] SEED_I = LFSR_SEED ^ 16'(i);
    scr1_tb_ahb_resp_ctrl_ch #(.WS_W(WS_W), .SEED(SEED_I)) u_ch (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_cfg_mode      (i_cfg_mode[i]),
      .i_cfg_ws        (i_cfg_ws[i]),
      .i_cfg_err_addr  (i_cfg_err_addr[i]),
      .i_cfg_err_mask  (i_cfg_err_mask[i]),
      .i_htrans        (i_htrans[i]),
      .i_haddr         (i_haddr[i]),
      .o_hready        (o_hready[i]),
      .o_hresp         (o_hresp[i]),
      .o_dphase_vld    (o_dphase_vld[i]),
      .o_dphase_addr   (o_dphase_addr[i]),
      .o_stat_xfer_cnt (o_stat_xfer_cnt[i]),
      .o_stat_err_cnt  (o_stat_err_cnt[i])
    );
  end

endmodule

// File: tb/tb_scr1_tb_ahb_resp_ctrl.sv
// Bench for scr1_tb_ahb_resp_ctrl: timeline-based response model, directed
// scenarios with literal expectations, then randomized traffic.

module tb_scr1_tb_ahb_resp_ctrl;
  localparam int          NCH  = 2;
  localparam int          WS_W = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0][1:0]      cfg_mode, htrans;
  logic [NCH-1:0][WS_W-1:0] cfg_ws;
  logic [NCH-1:0][31:0]     err_addr, err_mask, haddr;
  logic [NCH-1:0]           hready, hresp, dvld;
  logic [NCH-1:0][31:0]     daddr, xcnt;
  logic [NCH-1:0][15:0]     ecnt;

  scr1_tb_ahb_resp_ctrl #(.NCH(NCH), .WS_W(WS_W), .LFSR_SEED(SEED)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_mode(cfg_mode), .i_cfg_ws(cfg_ws),
    .i_cfg_err_addr(err_addr), .i_cfg_err_mask(err_mask), .i_htrans(htrans),
    .i_haddr(haddr), .o_hready(hready), .o_hresp(hresp), .o_dphase_vld(dvld),
    .o_dphase_addr(daddr), .o_stat_xfer_cnt(xcnt), .o_stat_err_cnt(ecnt)
  );

  // Model: each accepted transfer appends its future per-cycle outputs.
  typedef struct packed {logic rdy; logic rsp; logic vld;} exp_t;
  localparam exp_t E_IDLE = '{rdy: 1'b1, rsp: 1'b0, vld: 1'b0};
  localparam exp_t E_WAIT = '{rdy: 1'b0, rsp: 1'b0, vld: 1'b0};
  localparam exp_t E_OK   = '{rdy: 1'b1, rsp: 1'b0, vld: 1'b1};
  localparam exp_t E_ERR1 = '{rdy: 1'b0, rsp: 1'b1, vld: 1'b0};
  localparam exp_t E_ERR2 = '{rdy: 1'b1, rsp: 1'b1, vld: 1'b0};

  exp_t        sched [NCH][$];
  exp_t        cur   [NCH];
  logic [31:0] m_addr[NCH];
  logic [31:0] m_x   [NCH];
  logic [15:0] m_e   [NCH];
  logic [15:0] m_lfsr[NCH];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      sched[ch].delete();
      cur[ch]    = E_IDLE;
      m_addr[ch] = '0;
      m_x[ch]    = '0;
      m_e[ch]    = '0;
      m_lfsr[ch] = SEED ^ 16'(ch);
    end
  endtask

  // Apply the current inputs at the next edge, then check every output.
  task automatic step();
    logic rst_s;
    rst_s = rst;
    if (!rst_s) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (cur[ch].vld) m_x[ch]++;
        if (cur[ch].rdy && cur[ch].rsp && m_e[ch] != 16'hFFFF) m_e[ch]++;
        if (cur[ch].rdy && htrans[ch][1]) begin
          int   k;
          logic err;
          case (cfg_mode[ch])
            2'b00:   k = 0;
            2'b01:   k = int'(cfg_ws[ch]);
            default: k = (int'(m_lfsr[ch][WS_W-1:0]) < int'(cfg_ws[ch])) ?
                         int'(m_lfsr[ch][WS_W-1:0]) : int'(cfg_ws[ch]);
          endcase
          err = (cfg_mode[ch] == 2'b11) &&
                (((haddr[ch] ^ err_addr[ch]) & err_mask[ch]) == 32'd0);
          repeat (k) sched[ch].push_back(E_WAIT);
          if (err) begin
            sched[ch].push_back(E_ERR1);
            sched[ch].push_back(E_ERR2);
          end else begin
            sched[ch].push_back(E_OK);
          end
          m_lfsr[ch] = lfsr_next(m_lfsr[ch]);
          m_addr[ch] = haddr[ch];
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst_s) model_reset();
    else
      for (int ch = 0; ch < NCH; ch++)
        cur[ch] = (sched[ch].size() != 0) ? sched[ch].pop_front() : E_IDLE;
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("hready[%0d]", ch),     32'(hready[ch]), 32'(cur[ch].rdy));
      chk($sformatf("hresp[%0d]", ch),      32'(hresp[ch]),  32'(cur[ch].rsp));
      chk($sformatf("dphase_vld[%0d]", ch), 32'(dvld[ch]),   32'(cur[ch].vld));
      chk($sformatf("dphase_addr[%0d]", ch), daddr[ch],      m_addr[ch]);
      chk($sformatf("xfer_cnt[%0d]", ch),   xcnt[ch],        m_x[ch]);
      chk($sformatf("err_cnt[%0d]", ch),    32'(ecnt[ch]),   32'(m_e[ch]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    rst      = 1'b1;
    cfg_mode = '0;
    cfg_ws   = '0;
    err_addr = '0;
    err_mask = '0;
    htrans   = '0;
    haddr    = '0;
    model_reset();
    do_reset();

    chk("rst_hready", 32'(hready), 32'h3);
    chk("rst_hresp",  32'(hresp),  32'h0);
    chk("rst_vld",    32'(dvld),   32'h0);
    chk("rst_xcnt0",  xcnt[0],     32'h0);
    s = SEED;
    chk("lfsr_pin", 32'(lfsr_next(s)), 32'h5670);

    // Random waits from the seed: 1 wait, then 0 waits.
    cfg_mode[0] = 2'b10; cfg_ws[0] = 4'd15;
    htrans[0] = 2'b10; haddr[0] = 32'h40; step();
    htrans[0] = 2'b00;
    chk("rnd1_wait", 32'(hready[0]), 32'h0);
    step();
    chk("rnd1_done", 32'({hready[0], dvld[0]}), 32'h3);
    htrans[0] = 2'b10; haddr[0] = 32'h44; step();
    htrans[0] = 2'b00;
    chk("rnd2_done", 32'({hready[0], dvld[0]}), 32'h3);
    chk("rnd2_addr", daddr[0], 32'h44);
    cfg_ws[0] = 4'd0;
    htrans[0] = 2'b10; haddr[0] = 32'h48; step();
    htrans[0] = 2'b00;
    chk("rnd_ws0", 32'(dvld[0]), 32'h1);
    step();

    // Zero-wait back-to-back.
    do_reset();
    cfg_mode[0] = 2'b00;
    htrans[0] = 2'b10;
    for (int j = 0; j < 3; j++) begin
      haddr[0] = 32'h100 + 32'(4 * j);
      step();
      chk($sformatf("b2b_vld%0d", j),  32'({hready[0], dvld[0]}), 32'h3);
      chk($sformatf("b2b_addr%0d", j), daddr[0], 32'h100 + 32'(4 * j));
    end
    htrans[0] = 2'b00;
    step();
    chk("b2b_xcnt", xcnt[0], 32'd3);

    // Fixed three waits.
    cfg_mode[0] = 2'b01; cfg_ws[0] = 4'd3;
    htrans[0] = 2'b10; haddr[0] = 32'h200; step();
    htrans[0] = 2'b00;
    for (int j = 1; j <= 3; j++) begin
      chk($sformatf("fix_wait%0d", j), 32'({hready[0], dvld[0]}), 32'h0);
      step();
    end
    chk("fix_done", 32'({hready[0], dvld[0]}), 32'h3);
    step();
    chk("fix_after", 32'(dvld[0]), 32'h0);

    // Error injection then a normal access outside the region.
    cfg_mode[0] = 2'b11; cfg_ws[0] = 4'd0;
    err_addr[0] = 32'h2000; err_mask[0] = 32'hFFFF_F000;
    htrans[0] = 2'b10; haddr[0] = 32'h2010; step();
    htrans[0] = 2'b00;
    chk("err1", 32'({hready[0], hresp[0], dvld[0]}), 32'h2);
    step();
    chk("err2", 32'({hready[0], hresp[0], dvld[0]}), 32'h6);
    step();
    chk("err_cnt", 32'(ecnt[0]), 32'd1);
    htrans[0] = 2'b10; haddr[0] = 32'h3010; step();
    htrans[0] = 2'b00;
    chk("err_miss", 32'({hready[0], hresp[0], dvld[0]}), 32'h5);
    step();

    // Channel independence.
    do_reset();
    cfg_mode[0] = 2'b01; cfg_ws[0] = 4'd5; cfg_mode[1] = 2'b00;
    htrans = {2'b10, 2'b10}; haddr[0] = 32'h500; haddr[1] = 32'h600;
    step();
    htrans = '0;
    chk("ind_ch1", 32'(dvld[1]), 32'h1);
    chk("ind_ch0w", 32'(hready[0]), 32'h0);
    repeat (4) step();
    chk("ind_ch0w5", 32'(hready[0]), 32'h0);
    step();
    chk("ind_ch0", 32'({hready[0], dvld[0]}), 32'h3);
    step();
    chk("ind_x0", xcnt[0], 32'd1);
    chk("ind_x1", xcnt[1], 32'd1);

    // Reset during a long wait, then the LFSR must be back at its seed.
    cfg_ws[0] = 4'd7;
    htrans[0] = 2'b10; haddr[0] = 32'h700; step();
    htrans[0] = 2'b00;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rmw_hready", 32'(hready[0]), 32'h1);
    chk("rmw_vld", 32'(dvld[0]), 32'h0);
    chk("rmw_xcnt", xcnt[0], 32'd0);
    cfg_mode[0] = 2'b10; cfg_ws[0] = 4'd15;
    htrans[0] = 2'b10; haddr[0] = 32'h80; step();
    htrans[0] = 2'b00;
    chk("rmw_seed_wait", 32'(hready[0]), 32'h0);
    step();
    chk("rmw_seed_done", 32'(dvld[0]), 32'h1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 15) == 0) begin
          cfg_mode[ch] = 2'($urandom_range(0, 3));
          cfg_ws[ch]   = WS_W'($urandom_range(0, 15));
          err_addr[ch] = 32'h2000;
          err_mask[ch] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'hFFFF_F000;
        end
        htrans[ch] = 2'($urandom_range(0, 3));
        haddr[ch]  = {18'h0, 2'($urandom_range(1, 3)), 12'($urandom)};
      end
      step();
    end
    rst = 1'b0;
    htrans = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
